// File: rtl/life_scan.sv
// life_scan: row-multiplexed 8x8 LED driver with frame-synchronous grid swap.
// Ports: clk, reset (sync, active high), gridin[63:0], load, en in;
//        row[7:0] (one-hot), col[7:0], frame_done, pending out.
module life_scan #(
   parameter int DIV = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] gridin,
   input  logic        load,
   input  logic        en,
   output logic [7:0]  row,
   output logic [7:0]  col,
   output logic        frame_done,
   output logic        pending
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } st_t;

   st_t            st_q, st_d;
   logic [2:0]     ri_q, ri_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [63:0]    shadow_q, shadow_d;
   logic [63:0]    disp_q, disp_d;
   logic           pend_q, pend_d;
   logic [7:0]     row_q, row_d;
   logic [7:0]     col_q, col_d;
   logic           fd_q, fd_d;
   logic           swap;

   always_comb begin
      st_d     = st_q;
      ri_d     = ri_q;
      cnt_d    = cnt_q;
      swap     = 1'b0;
      shadow_d = shadow_q;
      disp_d   = disp_q;
      pend_d   = pend_q;

      if (!en) begin
         st_d  = IDLE;
         ri_d  = 3'd0;
         cnt_d = '0;
      end else begin
         unique case (st_q)
            IDLE: begin
               st_d  = BLANK;
               ri_d  = 3'd0;
               cnt_d = '0;
               swap  = 1'b1;
            end
            BLANK: begin
               st_d  = DRIVE;
               cnt_d = CW'(1);
            end
            DRIVE: begin
               if (cnt_q == CMAX) begin
                  st_d  = BLANK;
                  cnt_d = '0;
                  if (ri_q == 3'd7) begin
                     ri_d = 3'd0;
                     swap = 1'b1;
                  end else begin
                     ri_d = ri_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               st_d  = IDLE;
               ri_d  = 3'd0;
               cnt_d = '0;
            end
         endcase
      end

      // A load coinciding with the swap goes straight to the display.
      if (swap) begin
         if (load) begin
            disp_d   = gridin;
            shadow_d = gridin;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
         end
      end else if (load) begin
         shadow_d = gridin;
         pend_d   = 1'b1;
      end

      // Outputs decoded from next state so they are registered.
      row_d = 8'h00;
      col_d = 8'h00;
      fd_d  = 1'b0;
      if (st_d == DRIVE) begin
         row_d = 8'(1) << ri_d;
         col_d = disp_d[{ri_d, 3'b000} +: 8];
         fd_d  = (ri_d == 3'd7) && (cnt_d == CMAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q     <= IDLE;
         ri_q     <= 3'd0;
         cnt_q    <= '0;
         shadow_q <= 64'd0;
         disp_q   <= 64'd0;
         pend_q   <= 1'b0;
         row_q    <= 8'h00;
         col_q    <= 8'h00;
         fd_q     <= 1'b0;
      end else begin
         st_q     <= st_d;
         ri_q     <= ri_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         row_q    <= row_d;
         col_q    <= col_d;
         fd_q     <= fd_d;
      end
   end

   assign row        = row_q;
   assign col        = col_q;
   assign frame_done = fd_q;
   assign pending    = pend_q;

endmodule
